// File: rtl/ysyx_23060025_rd_arbiter.sv
// Read-channel arbiter: IFU (m0) and LSU (m1) share one AXI read port.
// Round-robin grant; an LSU read of a line still in the write buffer is held back.
`ifndef MACRO_CACHE_LINE_OFF_ADDR_W
`define MACRO_CACHE_LINE_OFF_ADDR_W 4
`endif

module ysyx_23060025_rd_arbiter #(
    parameter int ADDR_WIDTH            = 32,
    parameter int DATA_WIDTH            = 32,
    parameter int CACHE_LINE_OFF_ADDR_W = `MACRO_CACHE_LINE_OFF_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  m0_arvalid_i,
    output logic                  m0_arready_o,
    input  logic [ADDR_WIDTH-1:0] m0_araddr_i,
    input  logic [7:0]            m0_arlen_i,
    input  logic [2:0]            m0_arsize_i,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    output logic [1:0]            m0_rresp_o,
    output logic                  m0_rvalid_o,
    output logic                  m0_rlast_o,
    input  logic                  m0_rready_i,

    input  logic                  m1_arvalid_i,
    output logic                  m1_arready_o,
    input  logic [ADDR_WIDTH-1:0] m1_araddr_i,
    input  logic [7:0]            m1_arlen_i,
    input  logic [2:0]            m1_arsize_i,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic [1:0]            m1_rresp_o,
    output logic                  m1_rvalid_o,
    output logic                  m1_rlast_o,
    input  logic                  m1_rready_i,

    input  logic                  wb_busy_i,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,

    output logic [ADDR_WIDTH-1:0] axi_addr_r_addr_o,
    output logic [7:0]            axi_addr_r_len_o,
    output logic [2:0]            axi_addr_r_size_o,
    output logic                  axi_addr_r_valid_o,
    input  logic                  axi_addr_r_ready_i,

    input  logic [DATA_WIDTH-1:0] axi_r_data_i,
    input  logic [1:0]            axi_r_resp_i,
    input  logic                  axi_r_last_i,
    input  logic                  axi_r_valid_i,
    output logic                  axi_r_ready_o
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        {ADDR_WIDTH{1'b1}} << CACHE_LINE_OFF_ADDR_W;

    state_t                state;
    logic                  owner;
    logic                  last_grant;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [7:0]            ar_len_q;
    logic [2:0]            ar_size_q;

    logic                  idle;
    logic                  wb_hazard;
    logic                  elig0;
    logic                  elig1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  sel0;
    logic                  sel1;
    logic                  r_last_hs;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [7:0]            win_len;
    logic [2:0]            win_size;

    // Only the line tag matters: offset bits are masked out of the compare.
    assign wb_hazard = wb_busy_i &
        (((m1_araddr_i ^ wb_addr_i) & LINE_MASK) == '0);

    assign idle  = (state == IDLE) & ~reset;
    assign elig0 = m0_arvalid_i;
    assign elig1 = m1_arvalid_i & ~wb_hazard;

    // last_grant == 1 means m1 was served last, so m0 wins a tie.
    assign gnt0 = idle & elig0 & (~elig1 | last_grant);
    assign gnt1 = idle & elig1 & (~elig0 | ~last_grant);

    assign m0_arready_o = gnt0;
    assign m1_arready_o = gnt1;

    always_comb begin
        win_addr = m0_araddr_i;
        win_len  = m0_arlen_i;
        win_size = m0_arsize_i;
        unique case (1'b1)
            gnt1: begin
                win_addr = m1_araddr_i;
                win_len  = m1_arlen_i;
                win_size = m1_arsize_i;
            end
            default: ;
        endcase
    end

    assign sel0 = (state == DATA) & ~owner;
    assign sel1 = (state == DATA) & owner;

    assign axi_r_ready_o = (sel0 & m0_rready_i) | (sel1 & m1_rready_i);
    assign r_last_hs     = axi_r_valid_i & axi_r_ready_o & axi_r_last_i;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt0 | gnt1) begin
                        state      <= ADDR;
                        owner      <= gnt1;
                        last_grant <= gnt1;
                        ar_addr_q  <= win_addr;
                        ar_len_q   <= win_len;
                        ar_size_q  <= win_size;
                    end
                end
                ADDR: begin
                    if (axi_addr_r_ready_i) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (r_last_hs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign axi_addr_r_valid_o = (state == ADDR);
    assign axi_addr_r_addr_o  = ar_addr_q;
    assign axi_addr_r_len_o   = ar_len_q;
    assign axi_addr_r_size_o  = ar_size_q;

    assign m0_rvalid_o = sel0 & axi_r_valid_i;
    assign m0_rdata_o  = sel0 ? axi_r_data_i : '0;
    assign m0_rresp_o  = sel0 ? axi_r_resp_i : '0;
    assign m0_rlast_o  = sel0 & axi_r_last_i;

    assign m1_rvalid_o = sel1 & axi_r_valid_i;
    assign m1_rdata_o  = sel1 ? axi_r_data_i : '0;
    assign m1_rresp_o  = sel1 ? axi_r_resp_i : '0;
    assign m1_rlast_o  = sel1 & axi_r_last_i;

endmodule

// File: tb/tb_ysyx_23060025_rd_arbiter.sv
// Scoreboard bench for the read arbiter: directed requests push expected
// grants, AR payloads and beats; a negedge monitor pops and compares.
module tb_ysyx_23060025_rd_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        m0_arvalid_i, m0_arready_o;
    logic [31:0] m0_araddr_i;
    logic [7:0]  m0_arlen_i;
    logic [2:0]  m0_arsize_i;
    logic [31:0] m0_rdata_o;
    logic [1:0]  m0_rresp_o;
    logic        m0_rvalid_o, m0_rlast_o, m0_rready_i;

    logic        m1_arvalid_i, m1_arready_o;
    logic [31:0] m1_araddr_i;
    logic [7:0]  m1_arlen_i;
    logic [2:0]  m1_arsize_i;
    logic [31:0] m1_rdata_o;
    logic [1:0]  m1_rresp_o;
    logic        m1_rvalid_o, m1_rlast_o, m1_rready_i;

    logic        wb_busy_i;
    logic [31:0] wb_addr_i;

    logic [31:0] axi_addr_r_addr_o;
    logic [7:0]  axi_addr_r_len_o;
    logic [2:0]  axi_addr_r_size_o;
    logic        axi_addr_r_valid_o, axi_addr_r_ready_i;
    logic [31:0] axi_r_data_i;
    logic [1:0]  axi_r_resp_i;
    logic        axi_r_last_i, axi_r_valid_i, axi_r_ready_o;

    always #5 clock = ~clock;

    ysyx_23060025_rd_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .CACHE_LINE_OFF_ADDR_W(4)
    ) dut (
        .clock(clock), .reset(reset),
        .m0_arvalid_i(m0_arvalid_i), .m0_arready_o(m0_arready_o),
        .m0_araddr_i(m0_araddr_i), .m0_arlen_i(m0_arlen_i),
        .m0_arsize_i(m0_arsize_i), .m0_rdata_o(m0_rdata_o),
        .m0_rresp_o(m0_rresp_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_rlast_o(m0_rlast_o), .m0_rready_i(m0_rready_i),
        .m1_arvalid_i(m1_arvalid_i), .m1_arready_o(m1_arready_o),
        .m1_araddr_i(m1_araddr_i), .m1_arlen_i(m1_arlen_i),
        .m1_arsize_i(m1_arsize_i), .m1_rdata_o(m1_rdata_o),
        .m1_rresp_o(m1_rresp_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_rlast_o(m1_rlast_o), .m1_rready_i(m1_rready_i),
        .wb_busy_i(wb_busy_i), .wb_addr_i(wb_addr_i),
        .axi_addr_r_addr_o(axi_addr_r_addr_o),
        .axi_addr_r_len_o(axi_addr_r_len_o),
        .axi_addr_r_size_o(axi_addr_r_size_o),
        .axi_addr_r_valid_o(axi_addr_r_valid_o),
        .axi_addr_r_ready_i(axi_addr_r_ready_i),
        .axi_r_data_i(axi_r_data_i), .axi_r_resp_i(axi_r_resp_i),
        .axi_r_last_i(axi_r_last_i), .axi_r_valid_i(axi_r_valid_i),
        .axi_r_ready_o(axi_r_ready_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ar_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    int    grant_q[$];
    ar_t   ar_q[$];
    beat_t b0_q[$];
    beat_t b1_q[$];

    int checks   = 0;
    int failures = 0;

    // shared knobs, written by the stimulus process only
    int         ar_delay    = 0;
    logic       gap_en      = 1'b0;
    logic       slave_abort = 1'b0;
    logic [1:0] slv_resp    = 2'b00;
    logic       rr_stall    = 1'b0;
    logic       b2b_armed   = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int   cyc       = 0;
    int   grant_cyc = 0;
    int   last_cyc  = 0;
    logic burst_open = 1'b0;
    logic mon_owner  = 1'b0;

    task automatic on_grant(input logic m);
        int exp;
        check("single_grant", {63'b0, m0_arready_o & m1_arready_o}, 0);
        check("grant_while_busy", {63'b0, burst_open}, 0);
        if (grant_q.size() == 0) begin
            check("grant_unexpected", {63'b0, m}, 64'hff);
        end else begin
            exp = grant_q.pop_front();
            check("grant_who", {63'b0, m}, 64'(exp));
        end
        if (b2b_armed && m) check("b2b_gap", 64'(cyc - last_cyc), 1);
        burst_open = 1'b1;
        mon_owner  = m;
        grant_cyc  = cyc;
    endtask

    task automatic on_ar();
        ar_t e;
        if (ar_q.size() == 0) begin
            check("ar_unexpected", 1, 0);
        end else begin
            e = ar_q.pop_front();
            check("ar_addr", 64'(axi_addr_r_addr_o), 64'(e.addr));
            check("ar_len", 64'(axi_addr_r_len_o), 64'(e.len));
            check("ar_size", 64'(axi_addr_r_size_o), 64'(e.size));
            if (ar_delay == 0) check("ar_latency", 64'(cyc - grant_cyc), 1);
        end
    endtask

    task automatic on_beat(input logic m);
        beat_t       e;
        logic        rr;
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
        rr = m ? m1_rready_i : m0_rready_i;
        d  = m ? m1_rdata_o : m0_rdata_o;
        r  = m ? m1_rresp_o : m0_rresp_o;
        l  = m ? m1_rlast_o : m0_rlast_o;
        check(m ? "m1_rvalid_owner" : "m0_rvalid_owner",
              {63'b0, burst_open && (mon_owner == m)}, 1);
        check("r_ready_pass", {63'b0, axi_r_ready_o}, {63'b0, rr});
        if (rr) begin
            if ((m ? b1_q.size() : b0_q.size()) == 0) begin
                check("beat_unexpected", {63'b0, m}, 64'hff);
            end else begin
                e = m ? b1_q.pop_front() : b0_q.pop_front();
                check("r_data", 64'(d), 64'(e.data));
                check("r_resp", 64'(r), 64'(e.resp));
                check("r_last", {63'b0, l}, {63'b0, e.last});
                if (e.last) begin
                    burst_open = 1'b0;
                    last_cyc   = cyc;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                burst_open = 1'b0;
            end else begin
                if (m0_arvalid_i && m0_arready_o) on_grant(1'b0);
                if (m1_arvalid_i && m1_arready_o) on_grant(1'b1);
                if (axi_addr_r_valid_o && axi_addr_r_ready_i) on_ar();
                if (m0_rvalid_o) on_beat(1'b0);
                if (m1_rvalid_o) on_beat(1'b1);
            end
        end
    end

    // ---------------- AXI slave model ----------------
    logic [31:0] s_addr = '0;
    logic [7:0]  s_len  = '0;
    logic [7:0]  s_beat = '0;
    logic        s_active = 1'b0;
    logic        s_gap, s_ar_hs, s_r_hs, s_av;
    logic [31:0] s_a;
    logic [7:0]  s_l;
    int          ar_wait = 0;

    initial begin
        axi_addr_r_ready_i = 1'b1;
        axi_r_valid_i      = 1'b0;
        axi_r_data_i       = '0;
        axi_r_resp_i       = '0;
        axi_r_last_i       = 1'b0;
        forever begin
            @(negedge clock);
            s_ar_hs = axi_addr_r_valid_o & axi_addr_r_ready_i;
            s_r_hs  = axi_r_valid_i & axi_r_ready_o;
            s_av    = axi_addr_r_valid_o;
            s_a     = axi_addr_r_addr_o;
            s_l     = axi_addr_r_len_o;
            @(posedge clock);
            #1;
            s_gap = 1'b0;
            if (slave_abort) begin
                s_active = 1'b0;
            end else if (s_ar_hs) begin
                s_active = 1'b1;
                s_addr   = s_a;
                s_len    = s_l;
                s_beat   = '0;
            end else if (s_r_hs) begin
                if (s_beat == s_len) begin
                    s_active = 1'b0;
                end else begin
                    s_beat++;
                    s_gap = gap_en;
                end
            end
            if (s_ar_hs) ar_wait = 0;
            else if (s_av) ar_wait++;
            axi_addr_r_ready_i = (ar_wait >= ar_delay);
            axi_r_valid_i = s_active & ~s_gap;
            axi_r_data_i  = s_addr + {24'b0, s_beat};
            axi_r_resp_i  = slv_resp;
            axi_r_last_i  = (s_beat == s_len);
        end
    end

    // ---------------- stimulus ----------------
    logic h0, h1;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clock);
            h0 = m0_arvalid_i & m0_arready_o;
            h1 = m1_arvalid_i & m1_arready_o;
            @(posedge clock);
            #1;
            if (h0) m0_arvalid_i = 1'b0;
            if (h1) m1_arvalid_i = 1'b0;
            m0_rready_i = rr_stall ? ~m0_rready_i : 1'b1;
        end
    endtask

    task automatic issue(input logic m, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] resp);
        beat_t e;
        grant_q.push_back(m ? 1 : 0);
        ar_q.push_back('{addr: addr, len: len, size: 3'd2});
        for (int b = 0; b <= int'(len); b++) begin
            e.data = addr + 32'(b);
            e.resp = resp;
            e.last = (b == int'(len));
            if (m) b1_q.push_back(e);
            else   b0_q.push_back(e);
        end
        if (m) begin
            m1_araddr_i = addr; m1_arlen_i = len;
            m1_arsize_i = 3'd2; m1_arvalid_i = 1'b1;
        end else begin
            m0_araddr_i = addr; m0_arlen_i = len;
            m0_arsize_i = 3'd2; m0_arvalid_i = 1'b1;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((grant_q.size() + ar_q.size() + b0_q.size()
                + b1_q.size()) != 0 && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d pending expected 0", tag,
                     grant_q.size() + ar_q.size() + b0_q.size() + b1_q.size());
            grant_q.delete(); ar_q.delete(); b0_q.delete(); b1_q.delete();
        end
        tick(2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_m0_arready"}, {63'b0, m0_arready_o}, 0);
        check({tag, "_m1_arready"}, {63'b0, m1_arready_o}, 0);
        check({tag, "_ar_valid"}, {63'b0, axi_addr_r_valid_o}, 0);
        check({tag, "_r_ready"}, {63'b0, axi_r_ready_o}, 0);
        check({tag, "_m0_rvalid"}, {63'b0, m0_rvalid_o}, 0);
        check({tag, "_m1_rvalid"}, {63'b0, m1_rvalid_o}, 0);
        check({tag, "_ar_addr"}, 64'(axi_addr_r_addr_o), 0);
        check({tag, "_ar_len"}, 64'(axi_addr_r_len_o), 0);
    endtask

    initial begin
        int n;
        m0_arvalid_i = 1'b1; m0_araddr_i = 32'h8000_0000;
        m0_arlen_i = 8'd3; m0_arsize_i = 3'd2; m0_rready_i = 1'b1;
        m1_arvalid_i = 1'b1; m1_araddr_i = 32'h8000_0040;
        m1_arlen_i = 8'd1; m1_arsize_i = 3'd2; m1_rready_i = 1'b1;
        wb_busy_i = 1'b0; wb_addr_i = '0;

        // requests held during reset must not be acknowledged
        tick(2);
        check_quiet("reset");
        m0_arvalid_i = 1'b0;
        m1_arvalid_i = 1'b0;
        reset = 1'b0;
        tick();

        // single IFU burst, slave ready immediately
        issue(1'b0, 32'h8000_0000, 8'd3, 2'b00);
        wait_idle("single_m0");

        // round robin from a fresh reset: m0, m1, then m0 again
        do_reset();
        issue(1'b0, 32'h8000_0100, 8'd1, 2'b00);
        issue(1'b1, 32'h8000_0200, 8'd1, 2'b00);
        wait_idle("rr_pair1");
        issue(1'b0, 32'h8000_0300, 8'd0, 2'b00);
        issue(1'b1, 32'h8000_0400, 8'd2, 2'b00);
        wait_idle("rr_pair2");

        // write-buffer line hazard holds m1 back
        wb_busy_i = 1'b1;
        wb_addr_i = 32'h8000_1008;
        issue(1'b1, 32'h8000_100C, 8'd1, 2'b00);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hazard_hold", {63'b0, m1_arready_o}, 0);
            tick();
        end
        wb_busy_i = 1'b0;
        wait_idle("hazard_release");

        // different line: granted at once; later wb changes are ignored
        wb_busy_i = 1'b1;
        wb_addr_i = 32'h8000_1008;
        issue(1'b1, 32'h8000_2000, 8'd1, 2'b00);
        #1;
        check("no_hazard_grant", {63'b0, m1_arready_o}, 1);
        tick();
        wb_addr_i = 32'h8000_2000;
        wait_idle("wb_after_grant");
        wb_busy_i = 1'b0;

        // m1 waits behind a stalled, gappy m0 burst with error resp
        gap_en    = 1'b1;
        rr_stall  = 1'b1;
        ar_delay  = 2;
        slv_resp  = 2'b10;
        b2b_armed = 1'b1;
        issue(1'b0, 32'h8000_3000, 8'd3, 2'b10);
        tick(2);
        issue(1'b1, 32'h8000_4000, 8'd1, 2'b10);
        n = 0;
        while (b0_q.size() != 0 && n < 200) begin
            #1;
            check("m1_wait_burst", {63'b0, m1_arready_o}, 0);
            tick();
            n++;
        end
        wait_idle("mid_burst");
        gap_en    = 1'b0;
        rr_stall  = 1'b0;
        ar_delay  = 0;
        slv_resp  = 2'b00;
        b2b_armed = 1'b0;
        tick(2);

        // reset after beat 2 of 4 abandons the burst
        issue(1'b0, 32'h8000_5000, 8'd3, 2'b00);
        n = 0;
        while (b0_q.size() != 2 && n < 100) begin
            tick();
            n++;
        end
        check("reach_beat2", 64'(b0_q.size()), 2);
        reset = 1'b1;
        #1;
        check_quiet("async_reset");
        b0_q.delete();
        tick(2);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("post_reset_m0_rvalid", {63'b0, m0_rvalid_o}, 0);
            check("post_reset_r_ready", {63'b0, axi_r_ready_o}, 0);
            tick();
        end
        slave_abort = 1'b1;
        tick(2);
        slave_abort = 1'b0;
        issue(1'b1, 32'h8000_6000, 8'd2, 2'b00);
        wait_idle("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end expected summary");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ysyx_23060025_rd_arbiter.md
YSYX_23060025_RD_ARBITER -- requirements
Module: ysyx_23060025_rd_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 32, beat width; CACHE_LINE_OFF_ADDR_W, default `MACRO_CACHE_LINE_OFF_ADDR_W, line offset bits.
REQ-002 SHALL have ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- m0_arvalid_i / m0_arready_o  in/out  1/1  IFU read-request handshake (master 0).
- m0_araddr_i / m0_arlen_i / m0_arsize_i  in  ADDR_WIDTH/8/3  IFU request address, burst length, beat size.
- m0_rdata_o / m0_rresp_o / m0_rvalid_o / m0_rlast_o  out  DATA_WIDTH/2/1/1  IFU read data, response, valid, last-beat flag.
- m0_rready_i  in  1  IFU accepts the read beat.
- m1_*  same set as m0_*  LSU read path (master 1).
- wb_busy_i  in  1  write buffer not idle.
- wb_addr_i  in  ADDR_WIDTH  write buffer pending address.
- axi_addr_r_addr_o / axi_addr_r_len_o / axi_addr_r_size_o  out  ADDR_WIDTH/8/3  AXI AR channel payload.
- axi_addr_r_valid_o / axi_addr_r_ready_i  out/in  1/1  AXI AR handshake.
- axi_r_data_i / axi_r_resp_i / axi_r_last_i  in  DATA_WIDTH/2/1  AXI R channel payload.
- axi_r_valid_i / axi_r_ready_o  in/out  1/1  AXI R handshake.

Function
REQ-003 SHALL implement states IDLE, ADDR, DATA; IDLE->ADDR on a grant; ADDR->DATA on axi_addr_r_valid_o & axi_addr_r_ready_i; DATA->IDLE on axi_r_valid_i & axi_r_ready_o & axi_r_last_i.
REQ-004 Master i SHALL be eligible when mi_arvalid_i=1; master 1 SHALL additionally be ineligible while wb_busy_i=1 and m1_araddr_i[ADDR_WIDTH-1:CACHE_LINE_OFF_ADDR_W] == wb_addr_i[ADDR_WIDTH-1:CACHE_LINE_OFF_ADDR_W] (read-after-write line hazard).
REQ-005 In IDLE, one eligible master SHALL be granted; with both eligible, the master not recorded in last_grant wins (round-robin); last_grant updates on every grant.
REQ-006 mi_arready_o SHALL be 1 only in IDLE in the cycle master i is granted (combinational from eligibility); 0 otherwise.
REQ-007 On grant, araddr/arlen/arsize of the winner SHALL be registered; axi_addr_r_* payload SHALL be driven from this register, stable throughout ADDR.
REQ-008 axi_addr_r_valid_o SHALL equal (state==ADDR); AR issue occurs at earliest one cycle after grant.
REQ-009 In DATA, the granted master's mi_rvalid_o SHALL equal axi_r_valid_i; its rdata/rresp/rlast SHALL pass through combinationally; axi_r_ready_o SHALL equal the granted master's mi_rready_i.
REQ-010 The non-granted master's rvalid_o SHALL be 0 at all times; in IDLE/ADDR both rvalid_o SHALL be 0 and axi_r_ready_o SHALL be 0.
REQ-011 Grant SHALL be held from grant until the last-beat handshake; no re-arbitration mid-burst regardless of request changes.
REQ-012 A master deasserting arvalid before grant SHALL lose nothing; requests are only consumed on mi_arvalid_i & mi_arready_o.
REQ-013 wb_busy_i changes after a grant SHALL NOT affect the granted transaction.
REQ-014 axi_r_resp_i nonzero SHALL be forwarded unchanged; burst termination still requires rlast.
REQ-015 Returning to IDLE and granting a new request SHALL take one cycle (back-to-back: grant in the cycle after last beat).

Reset
REQ-016 On reset assertion, state SHALL become IDLE immediately and last_grant SHALL become master 1 (master 0 wins the first tie).
REQ-017 During reset, all *_valid_o, *_ready_o and mi_rvalid_o SHALL be 0; the registered AR payload SHALL be 0.
REQ-018 Reset mid-burst SHALL abandon the transaction; no beats are forwarded after reset deassertion until a new grant.

Verification
REQ-019 Only m0 requests addr 0x8000_0000, len 3; slave ready immediately -> m0_arready_o pulses once, AR issued next cycle with len 3, four beats reach m0 only, IDLE after rlast.
REQ-020 m0 and m1 request in the same cycle out of reset -> m0 granted first; after its rlast, m1 granted; third simultaneous pair -> m0 again.
REQ-021 wb_busy_i=1, wb_addr_i=0x8000_1008, m1 reads 0x8000_100C (line offset 4 bits) -> m1_arready_o stays 0 until wb_busy_i falls; m1 reads 0x8000_2000 -> granted immediately.
REQ-022 m0 burst in DATA, m1 asserts arvalid, slave inserts rvalid gaps and m0 stalls rready -> m1 never sees rvalid, m1_arready_o stays 0 until m0 rlast handshake.
REQ-023 Reset asserted in DATA after beat 2 of 4 -> all outputs 0 asynchronously; after deassertion the remaining beats are not forwarded and a new m1 request is granted normally.
